gpio_regs_ext: RTL

Next-generation GPIO register block for the SoC peripheral bus, parametrised in pin count. Adds the following over the current GPIO:
- atomic set/clear/toggle of output data
- per-pin interrupt mode: rising, falling, both edges, high level, low level
- per-pin input debounce with a shared programmable sample tick

Sits behind the same simple internal register interface (addr/wdata/wen/ren/rdata) as the existing GPIO core.

---
 rtl/gpio_ext_pkg.sv | 44 ++++
 rtl/gpio_debounce.sv | 51 +++++
 rtl/gpio_regs_ext.sv | 138 +++++++++++++
 3 files changed

// File: rtl/gpio_ext_pkg.sv
// ---------------------------------------------------------------------------
// gpio_ext_pkg : register offsets, interrupt mode encoding and helpers for
//                the extended GPIO register block.
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package gpio_ext_pkg;

  localparam logic [7:0] GPIO_IDR     = 8'h00;
  localparam logic [7:0] GPIO_ODR     = 8'h04;
  localparam logic [7:0] GPIO_ODR_SET = 8'h08;
  localparam logic [7:0] GPIO_ODR_CLR = 8'h0C;
  localparam logic [7:0] GPIO_ODR_TGL = 8'h10;
  localparam logic [7:0] GPIO_DR      = 8'h14;
  localparam logic [7:0] GPIO_IER     = 8'h18;
  localparam logic [7:0] GPIO_ISR     = 8'h1C;
  localparam logic [7:0] GPIO_ITYPE   = 8'h20;
  localparam logic [7:0] GPIO_IPOL    = 8'h24;
  localparam logic [7:0] GPIO_IBOTH   = 8'h28;
  localparam logic [7:0] GPIO_DBCR    = 8'h2C;
  localparam logic [7:0] GPIO_DBER    = 8'h30;

  typedef struct packed {
    logic itype;
    logic ipol;
    logic iboth;
  } irq_mode_t;

  function automatic int db_cnt_width(input int samples);
    return $clog2(samples + 1);
  endfunction

  // IBOTH only has meaning in edge mode, where it overrides IPOL.
  function automatic logic irq_event(input irq_mode_t m, input logic filt,
                                     input logic rise, input logic fall);
    if (m.itype) return m.ipol ? ~filt : filt;
    if (m.iboth) return rise | fall;
    return m.ipol ? fall : rise;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gpio_debounce.sv
// ---------------------------------------------------------------------------
// gpio_debounce : single-pin debounce filter; accepts a new level after
//                 DB_SAMPLES consecutive differing samples taken on tick_i.
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gpio_debounce
  import gpio_ext_pkg::*;
#(
  parameter int DB_SAMPLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic clr_i,
  input  logic d_i,
  output logic q_o
);

  localparam int CW = db_cnt_width(DB_SAMPLES);
  localparam logic [CW-1:0] C_LAST = CW'(DB_SAMPLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_q   <= 1'b0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (tick_i) begin
      if (d_i != r_q) begin
        if (r_cnt == C_LAST) begin
          r_q   <= d_i;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign q_o = r_q;

endmodule

`default_nettype wire

// File: rtl/gpio_regs_ext.sv
// ---------------------------------------------------------------------------
// gpio_regs_ext : GPIO register block with atomic ODR updates, per-pin
//                 interrupt modes and per-pin input debounce.
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gpio_regs_ext
  import gpio_ext_pkg::*;
#(
  parameter int          N_PIN      = 32,
  parameter int          ADDR_W     = 32,
  parameter int          DATA_W     = 32,
  parameter int          DB_CNT_W   = 16,
  parameter int          DB_SAMPLES = 3,
  parameter int unsigned DBCR_RST   = 999
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              wen_i,
  input  logic              ren_i,
  output logic [DATA_W-1:0] rdata_o,
  input  logic [N_PIN-1:0]  gpio_i,
  output logic [N_PIN-1:0]  gpio_o,
  output logic [N_PIN-1:0]  gpio_en_o,
  output logic              gpio_int_o
);

  logic [N_PIN-1:0]    r_sync1, r_sync2, r_prev;
  logic [N_PIN-1:0]    r_odr, r_dr, r_ier, r_isr, r_itype, r_ipol, r_iboth, r_dber;
  logic [DB_CNT_W-1:0] r_dbcr, r_pre;

  logic [7:0]          w_addr;
  logic [N_PIN-1:0]    w_wd, w_w1c, w_filt, w_db_q, w_rise, w_fall, w_evt;
  logic                w_tick, w_dber_wr, w_dbcr_wr;
  logic                w_unused;

  assign w_addr    = addr_i[7:0];
  assign w_wd      = wdata_i[N_PIN-1:0];
  assign w_unused  = ^{addr_i, wdata_i};
  assign w_dber_wr = wen_i && (w_addr == GPIO_DBER);
  assign w_dbcr_wr = wen_i && (w_addr == GPIO_DBCR);
  assign w_w1c     = (wen_i && (w_addr == GPIO_ISR)) ? w_wd : '0;
  assign w_tick    = (r_pre == r_dbcr);
  assign w_rise    = w_filt & ~r_prev;
  assign w_fall    = ~w_filt & r_prev;

  for (genvar i = 0; i < N_PIN; i++) begin : g_pin
    irq_mode_t w_mode;
    assign w_mode = {r_itype[i], r_ipol[i], r_iboth[i]};

    gpio_debounce #(.DB_SAMPLES(DB_SAMPLES)) u_db (
      .clk    (clk),
      .rst    (rst),
      .tick_i (w_tick),
      .clr_i  (w_dber_wr && (w_wd[i] != r_dber[i])),
      .d_i    (r_sync2[i]),
      .q_o    (w_db_q[i])
    );

    assign w_filt[i] = r_dber[i] ? w_db_q[i] : r_sync2[i];
    // Output pins never raise events, whatever their mode.
    assign w_evt[i]  = irq_event(w_mode, w_filt[i], w_rise[i], w_fall[i])
                       & r_ier[i] & ~r_dr[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_odr   <= '0;
      r_dr    <= '0;
      r_ier   <= '0;
      r_isr   <= '0;
      r_itype <= '0;
      r_ipol  <= '0;
      r_iboth <= '0;
      r_dber  <= '0;
      r_dbcr  <= DB_CNT_W'(DBCR_RST);
      r_pre   <= '0;
    end else begin
      r_sync1 <= gpio_i;
      r_sync2 <= r_sync1;
      r_prev  <= w_filt;
      // Hardware set is ORed after the clear so it wins a same-cycle W1C.
      r_isr   <= (r_isr & ~w_w1c) | w_evt;

      if (w_dbcr_wr || w_tick) r_pre <= '0;
      else                     r_pre <= r_pre + 1'b1;

      if (wen_i) begin
        case (w_addr)
          GPIO_ODR:     r_odr   <= w_wd;
          GPIO_ODR_SET: r_odr   <= r_odr | w_wd;
          GPIO_ODR_CLR: r_odr   <= r_odr & ~w_wd;
          GPIO_ODR_TGL: r_odr   <= r_odr ^ w_wd;
          GPIO_DR:      r_dr    <= w_wd;
          GPIO_IER:     r_ier   <= w_wd;
          GPIO_ITYPE:   r_itype <= w_wd;
          GPIO_IPOL:    r_ipol  <= w_wd;
          GPIO_IBOTH:   r_iboth <= w_wd;
          GPIO_DBCR:    r_dbcr  <= wdata_i[DB_CNT_W-1:0];
          GPIO_DBER:    r_dber  <= w_wd;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    if (ren_i) begin
      case (w_addr)
        GPIO_IDR:   rdata_o[N_PIN-1:0]    = w_filt;
        GPIO_ODR:   rdata_o[N_PIN-1:0]    = r_odr;
        GPIO_DR:    rdata_o[N_PIN-1:0]    = r_dr;
        GPIO_IER:   rdata_o[N_PIN-1:0]    = r_ier;
        GPIO_ISR:   rdata_o[N_PIN-1:0]    = r_isr;
        GPIO_ITYPE: rdata_o[N_PIN-1:0]    = r_itype;
        GPIO_IPOL:  rdata_o[N_PIN-1:0]    = r_ipol;
        GPIO_IBOTH: rdata_o[N_PIN-1:0]    = r_iboth;
        GPIO_DBCR:  rdata_o[DB_CNT_W-1:0] = r_dbcr;
        GPIO_DBER:  rdata_o[N_PIN-1:0]    = r_dber;
        default: ;
      endcase
    end
  end

  assign gpio_o     = r_odr;
  assign gpio_en_o  = r_dr;
  assign gpio_int_o = |r_isr;

endmodule

`default_nettype wire
